// File: rtl/fpga_ram_initiator.sv
`default_nettype none
// ============================================================================
// Module   : fpga_ram_initiator
// Brief    : Valid/ready master to single-port active-low FPGA block-RAM
//            bridge. Issues requests in order, captures read data one cycle
//            later and returns one in-order response per request through a
//            credit-limited response FIFO.
// Options  : FPGA_RAM_INITIATOR_ADDR_CHECK_EN - requests at or above
//            MEM_WORDS skip the RAM and return an error response.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_ram_initiator #(
    parameter int ADDR_WIDTH = 12,
    parameter int RSP_DEPTH  = 4,
    parameter int MEM_WORDS  = 3072
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [3:0]            req_be_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [OCC_W:0]   c_rsp_depth = (OCC_W+1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(RSP_DEPTH - 1);

    // Response FIFO storage (no reset needed: occupancy qualifies every read)
    logic        r_fifo_we   [RSP_DEPTH];
    logic        r_fifo_err  [RSP_DEPTH];
    logic [31:0] r_fifo_data [RSP_DEPTH];

    logic [OCC_W-1:0]      r_occ;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic                  r_inflight;
    logic                  r_infl_we;
    logic                  r_infl_err;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [31:0]           r_wdata_hold;

    logic        w_accept;
    logic        w_oob;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_data;
    logic [OCC_W:0] w_credits_used;

`ifdef FPGA_RAM_INITIATOR_ADDR_CHECK_EN
    assign w_oob = (32'(req_addr_i) >= 32'(MEM_WORDS));
`else
    assign w_oob = 1'b0;
`endif

    // Credits come from registered state only; a same-cycle pop is not counted
    assign w_credits_used = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
    assign req_ready_o    = !rst_i && (w_credits_used < c_rsp_depth);
    assign w_accept       = req_valid_i && req_ready_o;

    assign mem_csn_o   = !(w_accept && !w_oob);
    assign mem_wen_o   = !(w_accept && !w_oob && req_we_i);
    assign mem_be_o    = (w_accept && !w_oob) ? req_be_i : 4'b0000;
    assign mem_addr_o  = w_accept ? req_addr_i  : r_addr_hold;
    assign mem_wdata_o = w_accept ? req_wdata_i : r_wdata_hold;

    // Writes and errored accesses return zero data rather than bus garbage
    assign w_push      = r_inflight;
    assign w_push_data = (r_infl_we || r_infl_err) ? 32'h0 : mem_rdata_i;
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    assign rsp_valid_o = (r_occ != '0);
    assign rsp_we_o    = rsp_valid_o && r_fifo_we[r_rptr];
    assign rsp_err_o   = rsp_valid_o && r_fifo_err[r_rptr];
    assign rsp_rdata_o = rsp_valid_o ? r_fifo_data[r_rptr] : 32'h0;

    // Track the access awaiting capture and hold the last driven address/data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight   <= 1'b0;
            r_infl_we    <= 1'b0;
            r_infl_err   <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_infl_we    <= req_we_i;
                r_infl_err   <= w_oob;
                r_addr_hold  <= req_addr_i;
                r_wdata_hold <= req_wdata_i;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy alone
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Capture the completed access into the FIFO slot at the write pointer
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_we[r_wptr]   <= r_infl_we;
            r_fifo_err[r_wptr]  <= r_infl_err;
            r_fifo_data[r_wptr] <= w_push_data;
        end
    end

`ifndef SYNTHESIS
    // The credit rule must make a push into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && ({1'b0, r_occ} == c_rsp_depth)));
    a_params: assert property (@(posedge clk_i)
        (RSP_DEPTH >= 2) && (RSP_DEPTH <= 16) && (MEM_WORDS > 0));
`endif

endmodule
`default_nettype wire

// File: doc/fpga_ram_initiator.md
Name: fpga_ram_initiator

Overview:
- Initiator-side bridge that drives a single-port FPGA block-RAM bank of the private L2 region. The bank is chip-select/write-enable/byte-enable style, active-low, with 1-cycle read latency.
- Accepts requests from a valid/ready master (core or DMA adapter) and issues them to the RAM in order.
- Captures read data one cycle later and returns exactly one in-order response per request through a credit-limited response FIFO, so master backpressure never stalls or drops RAM data.

Parameters:
- ADDR_WIDTH, 12, word-address width of the RAM port.
- RSP_DEPTH, 4, response FIFO entries; legal range 2..16.
- MEM_WORDS, 3072, number of implemented words. Used only by the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=write, 0=read
- req_be_i  in  4  byte enables
- req_addr_i  in  ADDR_WIDTH  word address
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_we_o  out  1  response belongs to a write
- rsp_rdata_o  out  32  read data; 0 for writes
- rsp_err_o  out  1  error response; constant 0 unless the optional feature is enabled
- mem_csn_o  out  1  RAM chip select, active-low
- mem_wen_o  out  1  RAM write enable, active-low
- mem_be_o  out  4  RAM byte enables
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_wdata_o  out  32  RAM write data
- mem_rdata_i  in  32  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (asynchronous, rst_i high):
  - FIFO occupancy=0, in-flight flag=0, pointers=0.
  - Outputs: req_ready_o=0, rsp_valid_o=0, mem_csn_o=1, mem_wen_o=1, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_rdata_o/rsp_we_o/rsp_err_o=0.
  - Reset mid-operation discards in-flight and queued responses. The master must not expect them.
- Credit rule: req_ready_o = !rst_i && (occ + inflight < RSP_DEPTH).
  - Registered state only; no combinational path from req_valid_i or rsp_ready_i.
  - A same-cycle pop is not credited.
- Issue (cycle N, req_valid_i & req_ready_o):
  - mem_csn_o=0, mem_wen_o=!req_we_i, mem_be_o=req_be_i.
  - mem_addr_o/mem_wdata_o pass through combinationally.
  - Set inflight; latch we for the response.
- Idle cycles: mem_csn_o=1, mem_wen_o=1, mem_be_o=0, mem_addr_o and mem_wdata_o hold their last driven values.
- Capture (cycle N+1, inflight=1):
  - Push {we, we ? 0 : mem_rdata_i, err} into the FIFO; clear inflight unless a new request is accepted in N+1.
  - Credit rule guarantees space; push on full is impossible.
  - An assertion flags a violation.
- Response:
  - rsp_valid_o = occ != 0; outputs show the FIFO head.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Earliest response is cycle N+2 after accept.
- Simultaneous push and pop: occupancy unchanged, pointers both advance.
- Pointers wrap modulo RSP_DEPTH. Occupancy counter width is $clog2(RSP_DEPTH+1).
- Ordering: responses strictly in acceptance order; reads and writes share one queue.
- Throughput: back-to-back accepts every cycle when RSP_DEPTH>=3 and the master pops every cycle. With RSP_DEPTH=2, at most 2 accepts per 3 cycles.

Optional Feature:
- Macro: FPGA_RAM_INITIATOR_ADDR_CHECK_EN.
- Defined:
  - An accepted request with req_addr_i >= MEM_WORDS does not access the RAM (mem_csn_o stays 1).
  - It still consumes a credit and produces an in-order response with rsp_err_o=1 and rsp_rdata_o=0.
- Undefined: no range check; every request accesses the RAM; rsp_err_o tied 0.

Test Plan:
- Reset then idle -> req_ready_o=1 from the first cycle after rst_i falls; mem_csn_o=1; rsp_valid_o=0.
- Write be=4'b0011, addr=0x010, wdata=0xDEADBEEF, then read addr=0x010 (RAM model returns 0x0000BEEF):
  - Write cycle: mem_csn_o=0, mem_wen_o=0.
  - Responses in order: {we=1, rdata=0} then {we=0, rdata=0x0000BEEF}, the read response at accept+2 or later.
- rsp_ready_i=0, 10 back-to-back reads, RSP_DEPTH=4 -> exactly 4 accepted, then req_ready_o=0. Release rsp_ready_i -> 10 responses in address order, none lost or duplicated.
- Continuous reads with rsp_ready_i=1, RSP_DEPTH=4 -> one accept per cycle over 100 cycles; FIFO never overflows.
- Assert rst_i with 3 responses queued and one in flight -> rsp_valid_o=0 immediately (asynchronous); no stale response after release.
- With FPGA_RAM_INITIATOR_ADDR_CHECK_EN, MEM_WORDS=3072, read addr=0xC00 -> mem_csn_o stays 1; response err=1, rdata=0. Following read of addr=0xBFF -> normal access, err=0.
